piso_mux_serializer: RTL and testbench

PISO_MUX_SERIALIZER -- requirements
Module: piso_mux_serializer

---
 rtl/piso_mux_serializer_pkg.sv | 21 ++
 rtl/piso_mux_serializer_mux.sv | 12 +
 rtl/piso_mux_serializer.sv | 97 +++++++++
 tb/tb_piso_mux_serializer.sv | 264 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/piso_mux_serializer_pkg.sv
// Shared types and constants for the byte-to-serial PISO serializer.
// Holds the FSM encoding and the bit-order dependent select helper.
package piso_mux_serializer_pkg;

  localparam int DATA_W = 8;
  localparam int SEL_W  = 3;

  localparam logic [SEL_W-1:0] LAST_IDX = SEL_W'(DATA_W - 1);

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_t;

  // Maps the accepted-bit count onto the mux select for the chosen bit order.
  function automatic logic [SEL_W-1:0] bit_sel(input logic lsb_first,
                                               input logic [SEL_W-1:0] cnt);
    return lsb_first ? cnt : (LAST_IDX - cnt);
  endfunction

endpackage

// File: rtl/piso_mux_serializer_mux.sv
// 8-to-1 bit multiplexer: picks I[sel] onto mux_op, purely combinational.
module mux_8x1
  import piso_mux_serializer_pkg::*;
(
  output logic              mux_op,
  input  logic [DATA_W-1:0] I,
  input  logic [SEL_W-1:0]  sel
);

  assign mux_op = I[sel];

endmodule

// File: rtl/piso_mux_serializer.sv
// Parallel-in serial-out serializer: latches a byte, then walks a mux select
// across it one accepted bit at a time, with back-to-back reload at the last bit.
module piso_mux_serializer
  import piso_mux_serializer_pkg::*;
#(
  parameter int LSB_FIRST = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_valid,
  output logic              in_ready,
  output logic [SEL_W-1:0]  sel,
  output logic              out_bit,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              done,
  output logic              busy
);

  // Handshakes: a transfer happens on a rising edge where valid && ready are both
  // high; valid never depends on ready, and only out_ready -> in_ready is combinational.

  state_t              r_state;
  state_t              w_state_nxt;
  logic [SEL_W-1:0]    r_cnt;
  logic [SEL_W-1:0]    w_cnt_nxt;
  logic [DATA_W-1:0]   r_data_q;
  logic [DATA_W-1:0]   w_data_nxt;
  logic                r_done;
  logic                w_done_nxt;
  logic                w_last;
  logic                w_bit_acc;
  logic                w_load;
  logic [SEL_W-1:0]    w_sel;
  logic                w_mux_op;

  assign w_last    = (r_cnt == LAST_IDX);
  assign w_bit_acc = (r_state == SHIFT) && out_ready;
  assign in_ready  = (r_state == IDLE) || ((r_state == SHIFT) && w_last && out_ready);
  assign w_load    = in_valid && in_ready;
  assign w_sel     = bit_sel(LSB_FIRST != 0, r_cnt);

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_data_nxt  = r_data_q;
    w_done_nxt  = 1'b0;
    if (r_state == IDLE) begin
      if (w_load) begin
        w_state_nxt = SHIFT;
        w_cnt_nxt   = '0;
        w_data_nxt  = in_data;
      end
    end else if (w_bit_acc) begin
      if (!w_last) begin
        w_cnt_nxt = r_cnt + 1'b1;
      end else begin
        // Last bit leaves: either reload without a bubble or fall back to IDLE.
        w_done_nxt = 1'b1;
        w_cnt_nxt  = '0;
        if (w_load) begin
          w_data_nxt = in_data;
        end else begin
          w_state_nxt = IDLE;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= IDLE;
      r_cnt    <= '0;
      r_data_q <= '0;
      r_done   <= 1'b0;
    end else begin
      r_state  <= w_state_nxt;
      r_cnt    <= w_cnt_nxt;
      r_data_q <= w_data_nxt;
      r_done   <= w_done_nxt;
    end
  end

  mux_8x1 u_mux (
    .mux_op (w_mux_op),
    .I      (r_data_q),
    .sel    (w_sel)
  );

  assign sel       = w_sel;
  assign out_bit   = w_mux_op;
  assign out_valid = (r_state == SHIFT);
  assign busy      = (r_state == SHIFT);
  assign done      = r_done;

endmodule

// File: tb/tb_piso_mux_serializer.sv
// Bench for piso_mux_serializer: one LSB-first and one MSB-first instance share
// stimulus; a per-instance queue of expected {sel, bit} pairs is checked each cycle.
module tb_piso_mux_serializer;

  logic       clk;
  logic       rst_n;
  logic [7:0] in_data;
  logic       in_valid;
  logic       out_ready;

  logic       lsb_in_ready, lsb_out_bit, lsb_out_valid, lsb_done, lsb_busy;
  logic [2:0] lsb_sel;
  logic       msb_in_ready, msb_out_bit, msb_out_valid, msb_done, msb_busy;
  logic [2:0] msb_sel;

  int checks   = 0;
  int failures = 0;

  // Reference model state (state after the upcoming rising edge once updated)
  logic       md_state = 1'b0;
  logic [2:0] md_cnt   = 3'd0;
  logic [7:0] md_data  = 8'h00;
  logic       md_done  = 1'b0;

  logic [3:0] exp_lsb_q[$];
  logic [3:0] exp_msb_q[$];

  piso_mux_serializer #(.LSB_FIRST(1)) u_dut_lsb (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_data   (in_data),
    .in_valid  (in_valid),
    .in_ready  (lsb_in_ready),
    .sel       (lsb_sel),
    .out_bit   (lsb_out_bit),
    .out_valid (lsb_out_valid),
    .out_ready (out_ready),
    .done      (lsb_done),
    .busy      (lsb_busy)
  );

  piso_mux_serializer #(.LSB_FIRST(0)) u_dut_msb (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_data   (in_data),
    .in_valid  (in_valid),
    .in_ready  (msb_in_ready),
    .sel       (msb_sel),
    .out_bit   (msb_out_bit),
    .out_valid (msb_out_valid),
    .out_ready (out_ready),
    .done      (msb_done),
    .busy      (msb_busy)
  );

  // Clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check_eq(input string tag, input logic [7:0] got, input logic [7:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic check_dut(input string name, input bit lsb,
                           input logic in_rdy, input logic [2:0] sel_o,
                           input logic bit_o, input logic valid_o,
                           input logic done_o, input logic busy_o,
                           input bit have_front, input logic [3:0] front);
    logic [2:0] e_sel;
    logic       e_bit;
    logic       e_rdy;
    e_rdy = !md_state || (md_cnt == 3'd7 && out_ready);
    if (md_state) begin
      if (!have_front) begin
        check_eq({name, ".queue_empty"}, 8'd0, 8'd1);
        e_sel = 3'd0;
        e_bit = 1'b0;
      end else begin
        e_sel = front[3:1];
        e_bit = front[0];
      end
    end else begin
      e_sel = lsb ? 3'd0 : 3'd7;
      e_bit = md_data[e_sel];
    end
    check_eq({name, ".out_valid"}, 8'(valid_o), 8'(md_state));
    check_eq({name, ".busy"},      8'(busy_o),  8'(md_state));
    check_eq({name, ".in_ready"},  8'(in_rdy),  8'(e_rdy));
    check_eq({name, ".done"},      8'(done_o),  8'(md_done));
    check_eq({name, ".sel"},       8'(sel_o),   8'(e_sel));
    check_eq({name, ".out_bit"},   8'(bit_o),   8'(e_bit));
  endtask

  // Scoreboard: compare on the falling edge, then advance the model to the
  // state the DUT will hold after the next rising edge.
  always @(negedge clk) begin
    logic acc, ir, ld, n_done;
    if (!rst_n) begin
      md_state = 1'b0;
      md_cnt   = 3'd0;
      md_data  = 8'h00;
      md_done  = 1'b0;
      exp_lsb_q.delete();
      exp_msb_q.delete();
    end
    check_dut("lsb", 1'b1, lsb_in_ready, lsb_sel, lsb_out_bit, lsb_out_valid,
              lsb_done, lsb_busy, exp_lsb_q.size() > 0,
              (exp_lsb_q.size() > 0) ? exp_lsb_q[0] : 4'h0);
    check_dut("msb", 1'b0, msb_in_ready, msb_sel, msb_out_bit, msb_out_valid,
              msb_done, msb_busy, exp_msb_q.size() > 0,
              (exp_msb_q.size() > 0) ? exp_msb_q[0] : 4'h0);
    if (rst_n) begin
      acc    = md_state && out_ready;
      ir     = !md_state || (md_cnt == 3'd7 && out_ready);
      ld     = in_valid && ir;
      n_done = acc && (md_cnt == 3'd7);
      if (acc) begin
        if (exp_lsb_q.size() > 0) void'(exp_lsb_q.pop_front());
        if (exp_msb_q.size() > 0) void'(exp_msb_q.pop_front());
      end
      if (!md_state) begin
        if (ld) begin
          md_state = 1'b1;
          md_cnt   = 3'd0;
          md_data  = in_data;
        end
      end else if (acc) begin
        if (md_cnt != 3'd7) begin
          md_cnt = md_cnt + 3'd1;
        end else begin
          md_cnt = 3'd0;
          if (ld) md_data = in_data;
          else    md_state = 1'b0;
        end
      end
      if (ld) begin
        for (int i = 0; i < 8; i++) begin
          exp_lsb_q.push_back({3'(i), in_data[i]});
          exp_msb_q.push_back({3'(7 - i), in_data[7 - i]});
        end
      end
      md_done = n_done;
    end
  end

  // Driver tasks
  task automatic drive_byte(input logic [7:0] d);
    int n;
    in_data  = d;
    in_valid = 1'b1;
    n = 0;
    @(negedge clk);
    while (!lsb_in_ready && n < 64) begin
      @(negedge clk);
      n++;
    end
    if (n >= 64) begin
      check_eq("drive_timeout", 8'd1, 8'd0);
      in_valid = 1'b0;
      return;
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while (lsb_busy && n < 64) begin
      @(posedge clk);
      #1;
      n++;
    end
    if (n >= 64) check_eq("idle_timeout", 8'd1, 8'd0);
    repeat (2) @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n     = 1'b0;
    in_data   = 8'h00;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;
    repeat (2) @(posedge clk);
    #1;

    // Basic byte, then MSB-first reference byte
    drive_byte(8'hA5);
    wait_idle();
    drive_byte(8'h80);
    wait_idle();

    // Stall three cycles with cnt = 4; in_valid during the stall must be ignored
    drive_byte(8'h3C);
    repeat (4) @(posedge clk);
    #1;
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_data   = 8'hFF;
    repeat (3) @(posedge clk);
    #1;
    out_ready = 1'b1;
    in_valid  = 1'b0;
    wait_idle();

    // Back-to-back bytes
    drive_byte(8'hFF);
    drive_byte(8'h00);
    wait_idle();

    // Reset in the middle of a byte
    drive_byte(8'h5A);
    repeat (5) @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check_eq("rst_async_out_valid", 8'(lsb_out_valid), 8'd0);
    check_eq("rst_async_in_ready",  8'(msb_in_ready),  8'd1);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    drive_byte(8'h01);
    wait_idle();

    // IDLE: in_data toggles with in_valid low
    for (int i = 0; i < 6; i++) begin
      in_data = 8'($urandom_range(0, 255));
      @(posedge clk);
      #1;
    end

    // Random traffic with random backpressure
    for (int i = 0; i < 600; i++) begin
      in_valid  = ($urandom_range(0, 3) != 0);
      in_data   = 8'($urandom_range(0, 255));
      out_ready = ($urandom_range(0, 3) != 0);
      @(posedge clk);
      #1;
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    wait_idle();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
